// File: rtl/key_event_scheduler_if.sv
// Event stream from key_event_scheduler to its consumer: show-ahead head, occupancy and
// a ready strobe that pops the head.
interface key_event_scheduler_if #(
    parameter int unsigned DEPTH = 16
) ();
    logic                     evt_valid;
    logic                     evt_ready;
    logic [11:0]              evt_data;
    logic [$clog2(DEPTH):0]   evt_count;

    modport master (
        output evt_valid,
        output evt_data,
        output evt_count,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_data,
        input  evt_count,
        output evt_ready
    );
endinterface

// File: rtl/key_event_scheduler.sv
// Queues key-press events in a show-ahead FIFO and injects typematic repeat entries for a
// held repeatable key. Entry format: {repeat, e0, is_ascii, 1'b0, code[7:0]}.
module key_event_scheduler #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned DELAY_CYCLES = 25_000_000,
    parameter int unsigned RATE_CYCLES  = 2_500_000,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input  logic                         clk,
    input  logic                         clrn,
    input  logic                         newKey,
    input  logic [7:0]                   scanCode,
    input  logic [7:0]                   scanCode_E0,
    input  logic [7:0]                   ASCII,
    input  logic                         isASCIIkey,
    input  logic                         ovf_clr,
    output logic                         overflow,
    key_event_scheduler_if.master        evt
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned MaxCyc = (DELAY_CYCLES > RATE_CYCLES) ? DELAY_CYCLES : RATE_CYCLES;
    localparam int unsigned TmrW   = (MaxCyc > 2) ? $clog2(MaxCyc) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } state_e;

    state_e            state_q, state_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic              held_e0_q, held_e0_d;
    logic [7:0]        held_code_q, held_code_d;
    logic [10:0]       held_entry_q, held_entry_d;

    logic [11:0]       mem_q [DEPTH];
    logic [11:0]       mem_d [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              cap_e0;
    logic [7:0]        cap_code;
    logic [11:0]       press_entry;
    logic              repeatable;
    logic              still_held;
    logic [TmrW-1:0]   term_cnt;
    logic              rep_fire;

    logic              pop;
    logic              full;
    logic              press_push;
    logic              rep_push;
    logic              push;
    logic              ovf_set;
    logic [11:0]       push_data;

    // Entry capture from the live key inputs.
    always_comb begin
        cap_e0      = (scanCode_E0 != 8'h00);
        cap_code    = isASCIIkey ? ASCII : (cap_e0 ? scanCode_E0 : scanCode);
        press_entry = {1'b0, cap_e0, isASCIIkey, 1'b0, cap_code};
        repeatable  = isASCIIkey || (scanCode == 8'h66) ||
                      (scanCode_E0 == 8'h6B) || (scanCode_E0 == 8'h74) ||
                      (scanCode_E0 == 8'h75) || (scanCode_E0 == 8'h72);
        still_held  = held_e0_q ? (scanCode_E0 == held_code_q) : (scanCode == held_code_q);
        term_cnt    = (state_q == StDelay) ? TmrW'(DELAY_CYCLES - 1) : TmrW'(RATE_CYCLES - 1);
    end

    // Repeat FSM: a press always wins over a repeat tick in the same cycle.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        held_e0_d    = held_e0_q;
        held_code_d  = held_code_q;
        held_entry_d = held_entry_q;
        rep_fire     = 1'b0;

        if (newKey && REPEAT_EN) begin
            timer_d = '0;
            if (repeatable) begin
                state_d      = StDelay;
                held_e0_d    = cap_e0;
                held_code_d  = cap_e0 ? scanCode_E0 : scanCode;
                held_entry_d = press_entry[10:0];
            end else begin
                state_d = StIdle;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    timer_d = '0;
                end
                StDelay, StRepeat: begin
                    if (!still_held) begin
                        state_d = StIdle;
                        timer_d = '0;
                    end else if (timer_q == term_cnt) begin
                        state_d  = StRepeat;
                        timer_d  = '0;
                        rep_fire = 1'b1;
                    end else begin
                        timer_d = timer_q + TmrW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            endcase
        end
    end

    // FIFO control; repeats leave the last slot free so a press is never crowded out.
    always_comb begin
        pop        = (count_q != '0) && evt.evt_ready;
        full       = (count_q == CntW'(DEPTH));
        press_push = newKey && (!full || pop);
        ovf_set    = newKey && full && !pop;
        rep_push   = rep_fire && (count_q < CntW'(DEPTH - 1));
        push       = press_push || rep_push;
        push_data  = newKey ? press_entry : {1'b1, held_entry_q};

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end

        wr_ptr_d = push ? (wr_ptr_q + PtrW'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PtrW'(1)) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end

        overflow_d = ovf_set || (overflow_q && !ovf_clr);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            held_e0_q    <= 1'b0;
            held_code_q  <= 8'h00;
            held_entry_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            held_e0_q    <= held_e0_d;
            held_code_q  <= held_code_d;
            held_entry_q <= held_entry_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage needs no reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_data  = (count_q != '0) ? mem_q[rd_ptr_q] : 12'h000;
    assign evt.evt_count = count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler with short repeat timing (delay 20, rate 5, depth 4).
module tb_key_event_scheduler;

    localparam int unsigned Depth = 4;

    logic       clk = 1'b0;
    logic       clrn;
    logic       newKey;
    logic [7:0] scanCode;
    logic [7:0] scanCode_E0;
    logic [7:0] ASCII;
    logic       isASCIIkey;
    logic       ovf_clr;
    logic       overflow;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    key_event_scheduler_if #(.DEPTH(Depth)) evt_if ();

    key_event_scheduler #(
        .DEPTH       (Depth),
        .DELAY_CYCLES(20),
        .RATE_CYCLES (5),
        .REPEAT_EN   (1'b1)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .newKey     (newKey),
        .scanCode   (scanCode),
        .scanCode_E0(scanCode_E0),
        .ASCII      (ASCII),
        .isASCIIkey (isASCIIkey),
        .ovf_clr    (ovf_clr),
        .overflow   (overflow),
        .evt        (evt_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        clrn             = 1'b0;
        newKey           = 1'b0;
        scanCode         = 8'h00;
        scanCode_E0      = 8'h00;
        ASCII            = 8'h00;
        isASCIIkey       = 1'b0;
        ovf_clr          = 1'b0;
        evt_if.evt_ready = 1'b0;
        cycles(2);
        clrn = 1'b1;
        cycles(1);
    endtask

    // Presents a key and pulses newKey across one edge; the key stays held afterwards.
    task automatic press(input logic [7:0] sc, input logic [7:0] e0, input logic [7:0] asc,
                         input logic is_asc);
        scanCode    = sc;
        scanCode_E0 = e0;
        ASCII       = asc;
        isASCIIkey  = is_asc;
        newKey      = 1'b1;
        cycles(1);
        newKey      = 1'b0;
    endtask

    task automatic pop_one();
        evt_if.evt_ready = 1'b1;
        cycles(1);
        evt_if.evt_ready = 1'b0;
    endtask

    initial begin
        // 1: reset state, single press, pop, ready on empty ignored
        do_reset();
        check("rst_valid", 32'(evt_if.evt_valid), 32'h0);
        check("rst_data", 32'(evt_if.evt_data), 32'h0);
        check("rst_count", 32'(evt_if.evt_count), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        press(8'h1C, 8'h00, 8'h61, 1'b1);
        check("t1_valid", 32'(evt_if.evt_valid), 32'h1);
        check("t1_data", 32'(evt_if.evt_data), 32'h261);
        check("t1_count", 32'(evt_if.evt_count), 32'h1);
        pop_one();
        check("t1_pop_valid", 32'(evt_if.evt_valid), 32'h0);
        pop_one();
        check("t1_empty_pop", 32'(evt_if.evt_count), 32'h0);

        // 2: held 'a', repeats at +20 and +25, then saturates at DEPTH-1
        do_reset();
        press(8'h1C, 8'h00, 8'h61, 1'b1);
        cycles(19);
        check("t2_cnt_p19", 32'(evt_if.evt_count), 32'h1);
        cycles(1);
        check("t2_cnt_p20", 32'(evt_if.evt_count), 32'h2);
        cycles(4);
        check("t2_cnt_p24", 32'(evt_if.evt_count), 32'h2);
        cycles(1);
        check("t2_cnt_p25", 32'(evt_if.evt_count), 32'h3);
        cycles(15);
        check("t2_cnt_p40", 32'(evt_if.evt_count), 32'h3);
        check("t2_ovf", 32'(overflow), 32'h0);
        scanCode = 8'h00;
        cycles(1);
        check("t2_head0", 32'(evt_if.evt_data), 32'h261);
        pop_one();
        check("t2_head1", 32'(evt_if.evt_data), 32'hA61);
        pop_one();
        check("t2_head2", 32'(evt_if.evt_data), 32'hA61);
        pop_one();
        check("t2_drained", 32'(evt_if.evt_count), 32'h0);

        // 3: full FIFO, overflow set/clear priority, push+pop when full
        do_reset();
        press(8'h12, 8'h00, 8'h00, 1'b0);
        press(8'h14, 8'h00, 8'h00, 1'b0);
        press(8'h11, 8'h00, 8'h00, 1'b0);
        press(8'h59, 8'h00, 8'h00, 1'b0);
        check("t3_cnt_full", 32'(evt_if.evt_count), 32'h4);
        check("t3_ovf_pre", 32'(overflow), 32'h0);
        press(8'h58, 8'h00, 8'h00, 1'b0);
        check("t3_cnt_drop", 32'(evt_if.evt_count), 32'h4);
        check("t3_ovf_set", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        press(8'h58, 8'h00, 8'h00, 1'b0);
        check("t3_set_wins", 32'(overflow), 32'h1);
        cycles(1);
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 32'(overflow), 32'h0);
        evt_if.evt_ready = 1'b1;
        press(8'h58, 8'h00, 8'h00, 1'b0);
        evt_if.evt_ready = 1'b0;
        check("t3_pp_count", 32'(evt_if.evt_count), 32'h4);
        check("t3_pp_ovf", 32'(overflow), 32'h0);
        check("t3_pp_head", 32'(evt_if.evt_data), 32'h014);
        pop_one();
        pop_one();
        pop_one();
        check("t3_tail", 32'(evt_if.evt_data), 32'h058);

        // 4: release before the delay expires, then re-hold without a press
        do_reset();
        press(8'h32, 8'h00, 8'h62, 1'b1);
        cycles(17);
        scanCode = 8'h00;
        cycles(1);
        cycles(22);
        check("t4_no_rep", 32'(evt_if.evt_count), 32'h1);
        check("t4_head", 32'(evt_if.evt_data), 32'h262);
        scanCode = 8'h32;
        cycles(25);
        check("t4_idle", 32'(evt_if.evt_count), 32'h1);

        // 5: E0 arrow repeats, shift press cancels repeating
        do_reset();
        press(8'h00, 8'h75, 8'h00, 1'b0);
        check("t5_press", 32'(evt_if.evt_data), 32'h475);
        cycles(20);
        check("t5_rep_cnt", 32'(evt_if.evt_count), 32'h2);
        cycles(1);
        press(8'h12, 8'h00, 8'h00, 1'b0);
        check("t5_shift_cnt", 32'(evt_if.evt_count), 32'h3);
        cycles(30);
        check("t5_stopped", 32'(evt_if.evt_count), 32'h3);
        check("t5_head0", 32'(evt_if.evt_data), 32'h475);
        pop_one();
        check("t5_head1", 32'(evt_if.evt_data), 32'hC75);
        pop_one();
        check("t5_head2", 32'(evt_if.evt_data), 32'h012);

        // 6: asynchronous reset mid-repeat clears everything without a clock edge
        do_reset();
        press(8'h1C, 8'h00, 8'h61, 1'b1);
        cycles(25);
        check("t6_cnt_pre", 32'(evt_if.evt_count), 32'h3);
        #2;
        clrn = 1'b0;
        #1;
        check("t6_valid", 32'(evt_if.evt_valid), 32'h0);
        check("t6_data", 32'(evt_if.evt_data), 32'h0);
        check("t6_count", 32'(evt_if.evt_count), 32'h0);
        check("t6_ovf", 32'(overflow), 32'h0);
        cycles(1);
        clrn = 1'b1;
        cycles(30);
        check("t6_fsm_idle", 32'(evt_if.evt_count), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
